// File: rtl/vadd_pkg.sv
// Shared definitions for the sequential vector adder.
// Op encodings, FSM states and saturation-limit helpers.
package vadd_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Largest signed value of a w-bit lane, zero-extended to 64 bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most-negative signed value of a w-bit lane; the low w bits
    // hold the two's-complement pattern 100..0.
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/vadd_lane.sv
// One signed lane of the vector adder, purely combinational.
// Ports: a, b operands; op 0=add 1=sub; sat saturate; res result; ovf overflow.
module vadd_lane
    import vadd_pkg::*;
#(
    parameter int LANE_W = 16
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              op,
    input  logic              sat,
    output logic [LANE_W-1:0] res,
    output logic              ovf
);

    logic [LANE_W:0] ax;
    logic [LANE_W:0] bx;
    logic [LANE_W:0] r;
    logic            sub;

    always_comb begin
        sub = (op == OP_SUB);
        ax  = {a[LANE_W-1], a};
        bx  = {b[LANE_W-1], b};
        // Invert after sign extension so b = most-negative still
        // yields the correct +2^(W-1) in the extended width.
        if (sub) begin
            bx = ~bx;
        end
        r   = ax + bx + {{LANE_W{1'b0}}, sub};
        ovf = r[LANE_W] ^ r[LANE_W-1];
        res = r[LANE_W-1:0];
        if (sat && ovf) begin
            // r[LANE_W] is the true sign of the unbounded result.
            res = r[LANE_W] ? LANE_W'(sat_min(LANE_W))
                            : LANE_W'(sat_max(LANE_W));
        end
    end

endmodule

// File: rtl/vadd_vec_seq.sv
// Multi-cycle vector add/sub, LANES_PER_CYCLE lanes per clock.
// Ports: clk, rst (sync, active high); start/op/sat/in_a/in_b request;
// sum/lane_ovf/ovf result; busy in progress; done completion pulse.
module vadd_vec_seq
    import vadd_pkg::*;
#(
    parameter int LANES           = 16,
    parameter int LANE_W          = 16,
    parameter int LANES_PER_CYCLE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    op,
    input  logic                    sat,
    input  logic [LANES*LANE_W-1:0] in_a,
    input  logic [LANES*LANE_W-1:0] in_b,
    output logic [LANES*LANE_W-1:0] sum,
    output logic [LANES-1:0]        lane_ovf,
    output logic                    ovf,
    output logic                    busy,
    output logic                    done
);

    localparam int CHUNKS = LANES / LANES_PER_CYCLE;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int VW     = LANES * LANE_W;
    localparam int CW     = LANES_PER_CYCLE * LANE_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

    if ((LANES % LANES_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("LANES must be a multiple of LANES_PER_CYCLE");
    end

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [VW-1:0]          a_q, a_d;
    logic [VW-1:0]          b_q, b_d;
    logic                   op_q, op_d;
    logic                   sat_q, sat_d;
    logic [VW-1:0]          stg_q, stg_d;
    logic [LANES-1:0]       stgo_q, stgo_d;
    logic [VW-1:0]          sum_q, sum_d;
    logic [LANES-1:0]       lovf_q, lovf_d;
    logic                   done_q, done_d;

    logic [CW-1:0]              ca;
    logic [CW-1:0]              cb;
    logic [CW-1:0]              cres;
    logic [LANES_PER_CYCLE-1:0] covf;
    logic                       accept;

    // Select the operand chunk for the current counter value.
    always_comb begin
        ca = a_q[int'(cnt_q)*CW +: CW];
        cb = b_q[int'(cnt_q)*CW +: CW];
    end

    for (genvar j = 0; j < LANES_PER_CYCLE; j++) begin : g_lane
        vadd_lane #(
            .LANE_W(LANE_W)
        ) u_lane (
            .a  (ca[j*LANE_W +: LANE_W]),
            .b  (cb[j*LANE_W +: LANE_W]),
            .op (op_q),
            .sat(sat_q),
            .res(cres[j*LANE_W +: LANE_W]),
            .ovf(covf[j])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sat_d   = sat_q;
        stg_d   = stg_q;
        stgo_d  = stgo_q;
        sum_d   = sum_q;
        lovf_d  = lovf_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept = start;
            end
            BUSY: begin
                stg_d[int'(cnt_q)*CW +: CW] = cres;
                stgo_d[int'(cnt_q)*LANES_PER_CYCLE +: LANES_PER_CYCLE] = covf;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = stg_d;
                    lovf_d  = stgo_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    // The completing edge also takes a new request so
                    // back-to-back operations run every CHUNKS cycles.
                    accept  = start;
                end
            end
        endcase
        if (accept) begin
            a_d     = in_a;
            b_d     = in_b;
            op_d    = op;
            sat_d   = sat;
            cnt_d   = '0;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            sat_q   <= 1'b0;
            stg_q   <= '0;
            stgo_q  <= '0;
            sum_q   <= '0;
            lovf_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sat_q   <= sat_d;
            stg_q   <= stg_d;
            stgo_q  <= stgo_d;
            sum_q   <= sum_d;
            lovf_q  <= lovf_d;
            done_q  <= done_d;
        end
    end

    assign sum      = sum_q;
    assign lane_ovf = lovf_q;
    assign ovf      = |lovf_q;
    assign busy     = (state_q == BUSY);
    assign done     = done_q;

endmodule

// File: tb/tb_vadd_vec_seq.sv
// Scoreboard bench for vadd_vec_seq (16 lanes x 16 bits, 4 per cycle).
// Stimulus pushes expected results; a monitor pops them on each done.
module tb_vadd_vec_seq;

    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int LPC    = 4;
    localparam int CHUNKS = LANES / LPC;
    localparam int VW     = LANES * LANE_W;

    typedef struct {
        logic [VW-1:0]    sum;
        logic [LANES-1:0] lovf;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             op;
    logic             sat;
    logic [VW-1:0]    in_a;
    logic [VW-1:0]    in_b;
    logic [VW-1:0]    sum;
    logic [LANES-1:0] lane_ovf;
    logic             ovf;
    logic             busy;
    logic             done;

    exp_t          sb[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [VW-1:0] last_sum = '0;

    vadd_vec_seq #(
        .LANES(LANES),
        .LANE_W(LANE_W),
        .LANES_PER_CYCLE(LPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .sat(sat),
        .in_a(in_a),
        .in_b(in_b),
        .sum(sum),
        .lane_ovf(lane_ovf),
        .ovf(ovf),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [VW-1:0] act, logic [VW-1:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endfunction

    function automatic logic [VW-1:0] rep(logic [LANE_W-1:0] v);
        return {LANES{v}};
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_sum", sum, e.sum);
                chk("sb_lane_ovf", VW'(lane_ovf), VW'(e.lovf));
                chk("sb_ovf", VW'(ovf), VW'(e.ovf));
            end
        end
    end

    task automatic issue(input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic o, input logic s,
                         input logic [VW-1:0] es, input logic [LANES-1:0] eo,
                         input bit push);
        exp_t e;
        in_a  = a;
        in_b  = b;
        op    = o;
        sat   = s;
        start = 1'b1;
        if (push) begin
            e.sum  = es;
            e.lovf = eo;
            e.ovf  = |eo;
            sb.push_back(e);
        end
    endtask

    // Walks edges E1..E(CHUNKS) after an accepted start at E0.
    task automatic track(input bit hold, input bit chain, input logic [VW-1:0] es);
        for (int k = 1; k <= CHUNKS; k++) begin
            if (k == CHUNKS && chain) begin
                issue(rep(16'h0001), rep(16'h0001), 1'b0, 1'b0,
                      rep(16'h0002), '0, 1'b1);
            end else begin
                start = hold && (k < CHUNKS);
            end
            @(posedge clk);
            #1;
            chk("done_timing", VW'(done), VW'(k == CHUNKS));
            if (k < CHUNKS) begin
                chk("busy_mid", VW'(busy), 1);
                chk("sum_hold", sum, last_sum);
            end else begin
                chk("busy_end", VW'(busy), VW'(chain));
            end
        end
        last_sum = es;
    endtask

    task automatic run(input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic o, input logic s,
                       input logic [VW-1:0] es, input logic [LANES-1:0] eo);
        issue(a, b, o, s, es, eo, 1'b1);
        @(posedge clk);
        #1;
        chk("busy_start", VW'(busy), 1);
        track(1'b0, 1'b0, es);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [VW-1:0] ma;
        logic [VW-1:0] mb;
        logic [VW-1:0] ms;
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        sat   = 1'b0;
        in_a  = '0;
        in_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", sum, '0);
        chk("rst_lane_ovf", VW'(lane_ovf), 0);
        chk("rst_ovf", VW'(ovf), 0);
        chk("rst_busy", VW'(busy), 0);
        chk("rst_done", VW'(done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(rep(16'h7FFF), rep(16'h0001), 1'b0, 1'b0, rep(16'h8000), '1);
        run(rep(16'h7FFF), rep(16'h0001), 1'b0, 1'b1, rep(16'h7FFF), '1);
        run(rep(16'h8000), rep(16'h0001), 1'b1, 1'b1, rep(16'h8000), '1);
        run(rep(16'h0000), rep(16'h8000), 1'b1, 1'b1, rep(16'h7FFF), '1);
        run(rep(16'h8000), rep(16'h0001), 1'b1, 1'b0, rep(16'h7FFF), '1);

        for (int i = 0; i < LANES; i++) begin
            ma[i*LANE_W +: LANE_W] = LANE_W'(i);
            mb[i*LANE_W +: LANE_W] = LANE_W'(2 * i);
            ms[i*LANE_W +: LANE_W] = LANE_W'(3 * i);
        end
        run(ma, mb, 1'b0, 1'b0, ms, '0);

        // start held high through busy: one completion only.
        issue(rep(16'h1234), rep(16'h1111), 1'b1, 1'b0, rep(16'h0123), '0, 1'b1);
        @(posedge clk);
        #1;
        track(1'b1, 1'b0, rep(16'h0123));
        @(posedge clk);
        #1;
        chk("hold_no_restart", VW'(busy), 0);

        // Back-to-back: a new start on the completing edge.
        issue(rep(16'hFFFF), rep(16'hFFFF), 1'b0, 1'b0, rep(16'hFFFE), '0, 1'b1);
        @(posedge clk);
        #1;
        track(1'b0, 1'b1, rep(16'hFFFE));
        track(1'b0, 1'b0, rep(16'h0002));

        // Reset two edges into an operation aborts it.
        issue(rep(16'h0005), rep(16'h0003), 1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", VW'(busy), 0);
        chk("abort_sum", sum, '0);
        chk("abort_lane_ovf", VW'(lane_ovf), 0);
        chk("abort_ovf", VW'(ovf), 0);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", VW'(done), 0);
        end

        chk("sb_empty", VW'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vadd_vec_seq.md
Name: vadd_vec_seq

Overview:
- Parametrised, multi-cycle successor to the 16-lane combinational vector adder in the vector datapath.
- Adds or subtracts two packed vectors of signed two's-complement lanes, processing LANES_PER_CYCLE lanes per clock.
- Optional saturation; per-lane and summary overflow reporting.
- Uses the same start/done convention as the rest of the vector unit, but done is a registered completion pulse rather than an echo of start.

Parameters:
- LANES, 16: number of vector lanes.
- LANE_W, 16: bits per lane (signed two's complement).
- LANES_PER_CYCLE, 4: lanes computed per clock. LANES must be an integer multiple of LANES_PER_CYCLE; elaboration fails otherwise.
- CHUNKS (derived, localparam) = LANES/LANES_PER_CYCLE: operation latency in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Accepted on a rising edge when busy=0.
- op  in  1  0 = add (a+b), 1 = subtract (a-b). Sampled with start.
- sat  in  1  1 = saturate on overflow, 0 = wrap. Sampled with start.
- in_a  in  LANES*LANE_W  operand A; lane i at [i*LANE_W +: LANE_W], lane 0 at LSBs.
- in_b  in  LANES*LANE_W  operand B, same packing.
- sum  out  LANES*LANE_W  result vector, same packing.
- lane_ovf  out  LANES  per-lane signed overflow flag.
- ovf  out  1  OR-reduction of lane_ovf.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at a clock edge): sum=0, lane_ovf=0, ovf=0, busy=0, done=0; FSM to IDLE; chunk counter=0.
- Reset mid-operation aborts the operation: no done pulse, outputs cleared.
- FSM states: IDLE, BUSY.
  - IDLE, start=1: latch in_a, in_b, op and sat into operand registers; counter=0; go to BUSY; busy=1.
  - BUSY: each cycle computes lanes [k*LPC, (k+1)*LPC) into an internal staging register, where k = counter. Counter increments each cycle.
  - BUSY at counter=CHUNKS-1: copy staging (including this final chunk) to sum and lane_ovf; set done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: start accepted at edge E0 → done high and sum valid from edge E0+CHUNKS. With LANES_PER_CYCLE=LANES, latency is 1.
- start while busy=1 is ignored; operands are not re-latched.
- start high in the done cycle (busy=0) is accepted. Back-to-back throughput is one operation per CHUNKS cycles.
- sum, lane_ovf and ovf hold their last values until the next completion. They never show partial results.
- Lane arithmetic: compute at LANE_W+1 bits.
  - Overflow when the two MSBs of the LANE_W+1-bit result differ (i.e. signed overflow).
  - sat=0: result is the low LANE_W bits.
  - sat=1 with overflow: positive overflow → 2^(W-1)-1; negative overflow → -2^(W-1).
  - lane_ovf is reported in both modes.
- Subtract: a + ~b + 1, done in the extended width. This gives correct overflow at b = most-negative value.
- done is never asserted without a preceding accepted start.

Decomposition:
- Package vadd_pkg:
  - op encoding constants OP_ADD=0, OP_SUB=1.
  - FSM state enum {IDLE, BUSY}.
  - Helper functions for saturation limits (max/min of a LANE_W signed value).
- Sub-module vadd_lane: combinational, one lane.
  - Inputs: a, b, op, sat. Outputs: res, ovf.
  - Parameter LANE_W.
  - Instantiated LANES_PER_CYCLE times; operands and outputs muxed by the chunk counter.

Test Plan (LANES=16, LANE_W=16, LANES_PER_CYCLE=4):
- Reset: assert rst 2 cycles → sum=0, lane_ovf=0x0000, ovf=0, busy=0, done=0.
- Wrap add: all a=0x7FFF, b=0x0001, op=0, sat=0; start at E0 → busy high E0..E4; at E4: done=1 for 1 cycle, every lane sum=0x8000, lane_ovf=0xFFFF, ovf=1.
- Saturating add/sub:
  - Wrap-add operands with sat=1 → every lane 0x7FFF, lane_ovf=0xFFFF.
  - a=0x8000, b=0x0001, op=1, sat=1 → 0x8000, ovf=1.
  - a=0x0000, b=0x8000, op=1, sat=1 → 0x7FFF, ovf=1.
- Mixed lanes: lane i a=i, b=2i, op=0 → lane i sum=3i, lane_ovf=0, ovf=0. Previous sum holds unchanged during E1..E3.
- Handshake:
  - start held high throughout busy → single done at E4.
  - New start (a=1, b=1) in the done cycle → accepted; done again at E8 with lanes=0x0002.
- Reset mid-operation: rst at E2 after start → busy=0, sum=0, no done pulse at E4.
